// File: rtl/main_memory_arbiter_pkg.sv
// main_memory_arbiter_pkg: shared types and widths for the main memory arbiter.
//   arb_state_e : sequencer states (idle, issue strobes, wait latency, respond).
//   req_id_e    : requester identity, REQ_D = 0 (data), REQ_IF = 1 (instruction fetch).
//   MEM_AW/MEM_DW : memory address and data widths.
package main_memory_arbiter_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  typedef enum logic {
    REQ_D  = 1'b0,
    REQ_IF = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way picker for the main memory arbiter.
// Build option: MAIN_MEMORY_ARB_RR_EN selects round-robin (ptr names the favoured requester
// on a tie); when undefined, data always beats instruction fetch and ptr is ignored.
// Ports:
//   d_req, if_req : pending requests
//   ptr           : requester favoured on a tie (round-robin build only)
//   winner        : chosen requester; only meaningful when a request is pending
module mem_arb_pick
  import main_memory_arbiter_pkg::*;
(
  input  logic    d_req,
  input  logic    if_req,
  input  req_id_e ptr,
  output req_id_e winner
);

`ifdef MAIN_MEMORY_ARB_RR_EN
  always_comb begin
    winner = REQ_D;
    if (d_req && if_req) begin
      winner = ptr;
    end else if (if_req) begin
      winner = REQ_IF;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign winner = (!d_req && if_req) ? REQ_IF : REQ_D;
`endif

endmodule

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: shares one single-port main memory between instruction fetch (IF)
// and data load/store (D). One transaction at a time: grant, hold strobes MEM_LATENCY
// cycles, then pulse rvalid. Out-of-range addresses (>= ADDR_WORDS) never strobe memory.
// Build option: MAIN_MEMORY_ARB_RR_EN enables round-robin arbitration (default: D first).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   if_req/if_addr/if_gnt           : fetch request handshake
//   if_rvalid/if_rdata              : fetch response
//   d_req/d_we/d_addr/d_wdata/d_gnt : data request handshake
//   d_rvalid/d_rdata/d_err          : data response (d_err = out-of-range address)
//   mem_address/mem_readEn/mem_writeEn/mem_data_in/mem_data_out : memory port
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_WORDS  = 103
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [MEM_AW-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [MEM_DW-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [MEM_AW-1:0] d_addr,
  input  logic [MEM_DW-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [MEM_DW-1:0] d_rdata,
  output logic              d_err,
  output logic [MEM_AW-1:0] mem_address,
  output logic              mem_readEn,
  output logic              mem_writeEn,
  output logic [MEM_DW-1:0] mem_data_in,
  input  logic [MEM_DW-1:0] mem_data_out
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
  // Cycles spent in StWait after the single StIssue cycle.
  localparam logic [CntW-1:0] WaitLoad = CntW'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  req_id_e           owner_q, owner_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [MEM_DW-1:0] wdata_q, wdata_d;
  logic              inrange_q, inrange_d;
  logic [MEM_DW-1:0] if_rdata_q, if_rdata_d;
  logic [MEM_DW-1:0] d_rdata_q, d_rdata_d;

  logic              any_req;
  logic              strobe_phase;
  logic              last_strobe;
  logic [MEM_AW-1:0] sel_addr;
  logic [MEM_DW-1:0] rd_word;
  req_id_e           winner;
  req_id_e           ptr;

  assign any_req = d_req | if_req;

  mem_arb_pick u_pick (
    .d_req  (d_req),
    .if_req (if_req),
    .ptr    (ptr),
    .winner (winner)
  );

`ifdef MAIN_MEMORY_ARB_RR_EN
  // Pointer favours whoever was not granted last; starts by favouring D.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_D;
    end else if (state_q == StIdle && any_req) begin
      ptr <= (winner == REQ_D) ? REQ_IF : REQ_D;
    end
  end
`else
  assign ptr = REQ_D;
`endif

  assign sel_addr = (winner == REQ_D) ? d_addr : if_addr;
  // Out-of-range reads return zero rather than whatever the memory drives.
  assign rd_word  = inrange_q ? mem_data_out : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    inrange_d   = inrange_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    last_strobe = 1'b0;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d   = StIssue;
          owner_d   = winner;
          addr_d    = sel_addr;
          we_d      = (winner == REQ_D) && d_we;
          wdata_d   = (winner == REQ_D) ? d_wdata : '0;
          inrange_d = sel_addr < MEM_AW'(ADDR_WORDS);
        end
      end
      StIssue: begin
        if (MEM_LATENCY <= 1) begin
          state_d     = StResp;
          last_strobe = 1'b1;
        end else begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end
      end
      StWait: begin
        if (cnt_q <= CntW'(1)) begin
          state_d     = StResp;
          cnt_d       = '0;
          last_strobe = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Read data is captured at the close of the final strobe cycle.
    if (last_strobe && !we_q) begin
      if (owner_q == REQ_IF) begin
        if_rdata_d = rd_word;
      end else begin
        d_rdata_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      owner_q    <= REQ_D;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      inrange_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      inrange_q  <= inrange_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    strobe_phase = (state_q == StIssue) || (state_q == StWait);

    if_gnt    = (state_q == StIssue) && (owner_q == REQ_IF);
    d_gnt     = (state_q == StIssue) && (owner_q == REQ_D);
    if_rvalid = (state_q == StResp) && (owner_q == REQ_IF);
    d_rvalid  = (state_q == StResp) && (owner_q == REQ_D);
    d_err     = d_rvalid && !inrange_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;

    mem_address = strobe_phase ? addr_q : '0;
    mem_readEn  = strobe_phase && inrange_q && !we_q;
    mem_writeEn = strobe_phase && inrange_q && we_q;
    mem_data_in = (strobe_phase && we_q) ? wdata_q : '0;
  end

endmodule
